// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128/192/256 key schedule generator with round-key read port
module aes_key_expander #(
  parameter int MAX_KEY_W = 256
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         valid,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_round,
  input  logic         rd_dec,
  output logic [127:0] rd_key
);

  // Schedule depth and largest legal key code follow from the widest key supported.
  localparam int NW = (MAX_KEY_W == 128) ? 44 : (MAX_KEY_W == 192) ? 52 : 60;
  localparam logic [3:0] MAX_NR = (MAX_KEY_W == 128) ? 4'd10 : (MAX_KEY_W == 192) ? 4'd12 : 4'd14;
  localparam logic [1:0] MAX_LEN = (MAX_KEY_W == 128) ? 2'd0 : (MAX_KEY_W == 192) ? 2'd1 : 2'd2;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t      state;
  logic [1:0]  len_q;
  logic [5:0]  idx;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic [31:0] w [NW];

  logic [5:0]  nk;
  logic [2:0]  nk_m1;
  logic [5:0]  last_idx;
  logic        len_ok;
  logic [31:0] prev_word;
  logic [31:0] old_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic        rd_over;
  logic [3:0]  rd_k;
  logic [5:0]  rd_base;
  logic [127:0] rd_word;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    return (len == 2'd0) ? 4'd10 : (len == 2'd1) ? 4'd12 : 4'd14;
  endfunction

  // Per-key-size constants and the next-word recurrence from w[i-1] and w[i-Nk].
  always_comb begin
    nk       = (len_q == 2'd0) ? 6'd4 : (len_q == 2'd1) ? 6'd6 : 6'd8;
    nk_m1    = (len_q == 2'd0) ? 3'd3 : (len_q == 2'd1) ? 3'd5 : 3'd7;
    last_idx = (len_q == 2'd0) ? 6'd43 : (len_q == 2'd1) ? 6'd51 : 6'd59;
    len_ok   = (key_len != 2'd3) && (key_len <= MAX_LEN);
    prev_word = w[idx - 6'd1];
    old_word  = w[idx - nk];
    // One shared SubWord: rotated input at Nk boundaries, plain input for the 256-bit mid-step.
    sub_in  = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (phase == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (len_q == 2'd2 && phase == 3'd4)
      temp = sub_out;
    else
      temp = prev_word;
  end

  // Read index resolution; out-of-range requests fall back to index 0 and are zeroed later.
  always_comb begin
    rd_over = (rd_round > num_rounds) || (rd_round > MAX_NR);
    rd_k    = rd_over ? 4'd0 : (rd_dec ? (num_rounds - rd_round) : rd_round);
    rd_base = {rd_k, 2'b00};
    rd_word = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
  end

  // Control FSM, schedule storage and registered read port.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      valid      <= 1'b0;
      num_rounds <= 4'd0;
      len_q      <= 2'd0;
      idx        <= 6'd4;
      phase      <= 3'd0;
      rcon       <= 8'h01;
      rd_key     <= '0;
      w          <= '{default: '0};
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q      <= key_len;
              num_rounds <= nr_of(key_len);
              valid      <= 1'b0;
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          w[0] <= key_in[255:224];
          w[1] <= key_in[223:192];
          w[2] <= key_in[191:160];
          w[3] <= key_in[159:128];
          if (len_q != 2'd0) begin
            w[4] <= key_in[127:96];
            w[5] <= key_in[95:64];
          end
          if (len_q == 2'd2) begin
            w[6] <= key_in[63:32];
            w[7] <= key_in[31:0];
          end
          idx   <= nk;
          phase <= 3'd0;
          rcon  <= 8'h01;
          state <= EXPAND;
        end
        EXPAND: begin
          w[idx] <= old_word ^ temp;
          if (phase == 3'd0)
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          phase <= (phase == nk_m1) ? 3'd0 : phase + 3'd1;
          if (idx == last_idx) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      rd_key <= (valid && !rd_over) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed self-checking bench for aes_key_expander
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start, start2;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rd_round;
  logic         rd_dec;
  logic         busy, done, err, valid;
  logic [3:0]   num_rounds;
  logic [127:0] rd_key;
  logic         busy2, done2, err2, valid2;
  logic [3:0]   num_rounds2;
  logic [127:0] rd_key2;

  int checks = 0;
  int failures = 0;
  int lat;
  bit saw_err;
  bit saw_done;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk(clk), .n_rst(n_rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .valid(valid), .num_rounds(num_rounds),
    .rd_round(rd_round), .rd_dec(rd_dec), .rd_key(rd_key)
  );

  aes_key_expander #(.MAX_KEY_W(128)) dut2 (
    .clk(clk), .n_rst(n_rst), .start(start2), .key_len(key_len), .key_in(key_in),
    .busy(busy2), .done(done2), .err(err2), .valid(valid2), .num_rounds(num_rounds2),
    .rd_round(rd_round), .rd_dec(rd_dec), .rd_key(rd_key2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int which, input logic [1:0] len, input logic [255:0] key,
                     input bit bump, output int latency);
    @(negedge clk);
    key_len = len;
    key_in  = key;
    if (which == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    latency = 0;
    saw_err = 1'b0;
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      latency++;
      #1;
      start = (bump && latency == 5);
      if (err) saw_err = 1'b1;
      if ((which == 0) ? done : done2) break;
    end
    start = 1'b0;
  endtask

  task automatic rd(input int which, input logic [3:0] r, input logic d,
                    input logic [127:0] exp, input string tag);
    @(negedge clk);
    rd_round = r;
    rd_dec   = d;
    @(posedge clk);
    #1;
    check(tag, (which == 0) ? rd_key : rd_key2, exp);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; start2 = 1'b0; key_len = 2'd0; key_in = '0;
    rd_round = 4'd0; rd_dec = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", valid, 0);
    check("rst_nr", num_rounds, 0);
    check("rst_rdkey", rd_key, 0);
    @(negedge clk);
    n_rst = 1'b1;

    run(0, 2'd0, K128, 1'b0, lat);
    check("lat128", lat, 41);
    check("valid128", valid, 1);
    check("busy_at_done", busy, 0);
    check("nr128", num_rounds, 10);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    rd(0, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "r128_10");
    rd(0, 4'd0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "r128_dec0");
    rd(0, 4'd0, 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "r128_0");
    rd(0, 4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605, "r128_1");
    rd(0, 4'd10, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, "r128_dec10");
    rd(0, 4'd11, 1'b0, 128'h0, "r128_11");

    @(negedge clk);
    key_len = 2'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);
    check("illegal_valid", valid, 1);
    @(posedge clk); #1;
    check("illegal_err_pulse", err, 0);
    check("illegal_busy2", busy, 0);
    rd(0, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "illegal_keep");

    run(0, 2'd1, K192, 1'b1, lat);
    check("lat192_bumped", lat, 47);
    check("bump_no_err", saw_err, 0);
    check("nr192", num_rounds, 12);
    rd(0, 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202, "r192_12");
    rd(0, 4'd13, 1'b0, 128'h0, "r192_13");

    run(0, 2'd2, K256, 1'b0, lat);
    check("lat256", lat, 53);
    check("nr256", num_rounds, 14);
    rd(0, 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e, "r256_14");
    rd(0, 4'd15, 1'b0, 128'h0, "r256_15");
    rd(0, 4'd0, 1'b0, 128'h603deb1015ca71be2b73aef0857d7781, "r256_0");
    rd(0, 4'd1, 1'b0, 128'h1f352c073b6108d72d9810a30914dff4, "r256_1");
    rd(0, 4'd14, 1'b1, 128'h603deb1015ca71be2b73aef0857d7781, "r256_dec14");

    @(negedge clk);
    key_len = 2'd2;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("cap_err", err2, 1);
    check("cap_busy", busy2, 0);
    check("cap_valid", valid2, 0);
    run(1, 2'd0, K128, 1'b0, lat);
    check("cap_lat128", lat, 41);
    rd(1, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "cap_r10");

    @(negedge clk);
    key_len = 2'd0;
    key_in  = K128;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", valid, 0);
    check("midrst_nr", num_rounds, 0);
    check("midrst_rdkey", rd_key, 0);
    @(negedge clk);
    n_rst = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    rd(0, 4'd10, 1'b0, 128'h0, "midrst_read0");

    run(0, 2'd0, K128, 1'b0, lat);
    check("rerun_lat", lat, 41);
    rd(0, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rerun_r10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 Parameter MAX_KEY_W, default 256, largest supported key width (legal values 128, 192, 256); sizes storage to 44/52/60 words.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to expand key_in using key_len.
REQ-005 key_len  input  2  key size: 00=128, 01=192, 10=256, 11=illegal.
REQ-006 key_in  input  256  cipher key, left-aligned: a 128-bit key occupies [255:128], a 192-bit key occupies [255:64]; unused low bits are ignored.
REQ-007 busy  output  1  high while expansion is in progress (LOAD, EXPAND).
REQ-008 done  output  1  one-cycle pulse when the schedule is complete.
REQ-009 err  output  1  one-cycle pulse when a start request is rejected.
REQ-010 valid  output  1  level; the stored schedule is complete and readable.
REQ-011 num_rounds  output  4  Nr of the latched key size (10/12/14); 0 after reset.
REQ-012 rd_round  input  4  round-key index to read.
REQ-013 rd_dec  input  1  when 1, the read index is reversed (decryption order).
REQ-014 rd_key  output  128  registered round key, word w[4r] in [127:96] through w[4r+3] in [31:0].

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, EXPAND, DONE; IDLE->LOAD on an accepted start, LOAD->EXPAND after 1 cycle, EXPAND->DONE after the final word is written, DONE->IDLE after 1 cycle.
REQ-016 A start SHALL be accepted only in IDLE, with key_len != 11, and with the key width <= MAX_KEY_W.
REQ-017 A rejected start in IDLE SHALL pulse err in the next cycle; the FSM, valid and storage are unchanged.
REQ-018 A start in any state other than IDLE SHALL be ignored, with no err pulse.
REQ-019 On acceptance the block SHALL latch key_len, set Nk=4/6/8 and Nr=10/12/14, update num_rounds, and clear valid on the next edge.
REQ-020 In the LOAD cycle the block SHALL write w[0..Nk-1] from key_in, MSB word first.
REQ-021 EXPAND SHALL write one word per cycle, w[i] for i = Nk .. 4*(Nr+1)-1, per FIPS-197.
- temp = w[i-1]
- if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}
- else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp)
- w[i] = w[i-Nk] ^ temp
REQ-022 Rcon SHALL be the sequence 01,02,04,08,10,20,40,80,1b,36; SubWord SHALL use four internal combinational AES S-box lookups.
REQ-023 Latency from the start-sampling edge to done high SHALL be 41 cycles for 128-bit keys, 47 for 192 and 53 for 256; valid SHALL rise together with done.
REQ-024 valid SHALL remain high until the next accepted start or reset.
REQ-025 The read index SHALL be rd_round when rd_dec=0 and Nr-rd_round when rd_dec=1; rd_key SHALL present words w[4k..4k+3] one cycle after rd_round/rd_dec are sampled.
REQ-026 rd_key SHALL be 0 when valid=0, when rd_round > Nr, or when rd_round exceeds the round capacity of MAX_KEY_W.
REQ-027 Reads SHALL be legal in every state; a read in DONE SHALL return the final schedule.

Reset
REQ-028 n_rst low SHALL force, asynchronously: state=IDLE, busy=0, done=0, err=0, valid=0, num_rounds=0, rd_key=0, and all stored words=0.
REQ-029 Reset asserted mid-expansion SHALL abandon the operation; no done pulse follows after reset is released.

Verification
REQ-030 128-bit key 2b7e151628aed2a6abf7158809cf4f3c -> done 41 cycles after start; read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; read round 0 with rd_dec=1 -> same value.
REQ-031 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles, num_rounds=12; read round 12 -> e98ba06f448c773c8ecc720401002202.
REQ-032 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles; read round 14 -> fe4890d1e6188d0b046df344706c631e; read round 15 -> 0.
REQ-033 key_len=11, or key_len=10 with MAX_KEY_W=128 -> err pulse, busy stays 0, valid unchanged; a second start issued while busy -> ignored, latency unchanged.
REQ-034 Reset asserted during cycle 20 of EXPAND -> all outputs 0 immediately, no done pulse; a fresh start after release completes normally.
